mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: DATA_W, default 32, operand and HI/LO width; the block SHALL be verified at 32 only.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; one clock, asynchronous, active-low, shared with the register file.
REQ-004 start  input  1  one-cycle request to begin the operation on op, src_a and src_b.
REQ-005 op  input  2  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 src_a  input  DATA_W  rs operand, taken from register-file read port 1 (dividend / multiplicand).
REQ-007 src_b  input  DATA_W  rt operand, taken from register-file read port 2 (divisor / multiplier).
REQ-008 hi_we, lo_we  input  1 each  MTHI / MTLO write strobes.
REQ-009 wdata  input  DATA_W  MTHI / MTLO write data.
REQ-010 busy  output  1  high while an operation is in flight; the pipeline stalls MFHI/MFLO and new MULT/DIV on busy.
REQ-011 done  output  1  one-cycle pulse when HI/LO hold a new result.
REQ-012 hi, lo  output  DATA_W each  architectural HI/LO registers, fed to the register-file write-back mux.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, CALC, FIX and DONE.
REQ-014 In IDLE, start=1 SHALL latch op, src_a and src_b on the clock edge and enter CALC; busy SHALL rise in the next cycle.
REQ-015 CALC SHALL run exactly 32 cycles, counted by a 5-bit counter, and SHALL process one bit per cycle.
- Multiply: shift-add on the operand magnitudes.
- Divide: restoring shift-subtract on the operand magnitudes.
REQ-016 FIX SHALL take 1 cycle and apply the sign correction for signed ops.
- Product: negated when the operand signs differ.
- Quotient: negated when the operand signs differ.
- Remainder: takes the sign of the dividend.
REQ-017 In DONE, HI and LO SHALL update and done SHALL be 1 for one cycle.
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: LO = quotient, HI = remainder.
REQ-018 The FSM SHALL return from DONE to IDLE on the next edge.
REQ-019 done SHALL first be high in the 34th cycle after the start edge.
REQ-020 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE.
REQ-021 A start accepted in DONE SHALL begin a new operation: back-to-back throughput is one operation per 34 cycles.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 op, src_a and src_b SHALL only be sampled on the accepting edge; later changes to them have no effect.
REQ-024 Divide by zero SHALL give LO = 32'hFFFFFFFF and HI = src_a, for both signed and unsigned divide.
REQ-025 Signed divide of 32'h80000000 by 32'hFFFFFFFF SHALL give LO = 32'h80000000 and HI = 0.
REQ-026 hi_we or lo_we in IDLE or DONE SHALL write wdata to the selected register on the next edge.
REQ-027 hi_we and lo_we SHALL be ignored while busy=1.
REQ-028 If hi_we or lo_we coincides with an accepted start, the write SHALL take effect and the later result SHALL overwrite it.
REQ-029 If a write coincides with the DONE-state result update, the result SHALL take priority.
REQ-030 hi and lo SHALL change only on a result update or an accepted write.

Reset
REQ-031 On rst_n=0 the block SHALL immediately go to state IDLE with counter=0, busy=0, done=0, hi=0, lo=0, and all operand and accumulator registers cleared.
REQ-032 Reset asserted during CALC or FIX SHALL abort the operation, with no HI/LO update and no done pulse.
REQ-033 After reset release, start SHALL be accepted in the first cycle.

Structure
REQ-034 The shared package mips_pkg SHALL hold these typedefs and constants:
- md_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
- md_state_t enum (IDLE, CALC, FIX, DONE).
- MD_ITER = 32.
REQ-035 The block SHALL be a single module; its datapath SHALL be a 64-bit accumulator plus a 32-bit operand register, shared by multiply and divide.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> done in cycle 34; HI = 32'hFFFFFFFE, LO = 32'h00000001.
- MULT -3 x 7 -> HI = 32'hFFFFFFFF, LO = 32'hFFFFFFEB.
- DIV -7 / 2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF; DIVU 100 / 7 -> LO = 14, HI = 2.
- DIVU 5 / 0 -> LO = 32'hFFFFFFFF, HI = 5; DIV 32'h80000000 / -1 -> LO = 32'h80000000, HI = 0.
- start and hi_we pulsed on cycle 10 of a running MULT -> both ignored; result unchanged; busy held.
- rst_n low for one cycle in cycle 20 of a DIV -> busy = 0, hi = lo = 0, no done pulse; a new MULTU 3 x 4 started right after release -> LO = 12.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types: HI/LO multiply/divide opcodes, FSM states and iteration count.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  localparam int MD_ITER = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO; one bit per cycle over magnitudes.
// Result lands 34 cycles after the accepting edge; start and MTHI/MTLO are ignored while busy.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CW = $clog2(MD_ITER);
  localparam int AW = 2 * DATA_W;

  md_state_t         state, state_nxt;
  md_op_t            op_q;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     acc, acc_step, res_fix;
  logic [DATA_W-1:0] opnd, mag_a, mag_b, quo, rem_out;
  logic [DATA_W:0]   sum, rem, diff;
  logic              sign_a, sign_b, op_signed, neg_a, neg_b, accept, is_div;

  assign op_signed = (md_op_t'(op) == MD_MULT) || (md_op_t'(op) == MD_DIV);
  assign neg_a     = op_signed & src_a[DATA_W-1];
  assign neg_b     = op_signed & src_b[DATA_W-1];
  assign mag_a     = neg_a ? -src_a : src_a;
  assign mag_b     = neg_b ? -src_b : src_b;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (cnt == CW'(MD_ITER - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply shifts the accumulator right, adding opnd into the top half when the
  // current multiplier bit is set. Divide shifts left and trial-subtracts opnd from
  // the partial remainder, shifting in a quotient bit of 1 only when it fits.
  always_comb begin
    sum  = {1'b0, acc[AW-1:DATA_W]} + {1'b0, opnd};
    rem  = acc[AW-1:DATA_W-1];
    diff = rem - {1'b0, opnd};
    if (is_div) begin
      acc_step = diff[DATA_W] ? {rem[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                              : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    end else begin
      acc_step = acc[0] ? {sum, acc[DATA_W-1:1]} : {1'b0, acc[AW-1:1]};
    end
  end

  // A zero divisor keeps the all-ones quotient unnegated so signed and unsigned agree.
  always_comb begin
    quo     = ((sign_a ^ sign_b) && (opnd != '0)) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    rem_out = sign_a ? -acc[AW-1:DATA_W] : acc[AW-1:DATA_W];
    if (is_div) res_fix = {rem_out, quo};
    else        res_fix = (sign_a ^ sign_b) ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MD_MULT;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (accept) begin
      op_q   <= md_op_t'(op);
      cnt    <= '0;
      acc    <= {{DATA_W{1'b0}}, mag_a};
      opnd   <= mag_b;
      sign_a <= neg_a;
      sign_b <= neg_b;
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      {hi, lo} <= res_fix;
    end else if (!busy) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests;
  int failed;

  mult_div_unit #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on signed/unsigned values, with the two architected corner cases.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sa = a;
    sb = b;
    case (o)
      2'd0: begin
        sp = longint'(sa) * longint'(sb);
        {eh, el} = sp;
      end
      2'd1: begin
        up = {32'b0, a} * {32'b0, b};
        {eh, el} = up;
      end
      2'd2: begin
        if (b == 32'd0) begin
          el = 32'hFFFFFFFF; eh = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          el = 32'h80000000; eh = 32'd0;
        end else begin
          el = sa / sb; eh = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFFFFFF; eh = a;
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle with start low.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit intrude, input bit coin, input logic [31:0] cval);
    logic [31:0] eh, el;
    int n;
    model(o, a, b, eh, el);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    chk("busy_rise", 64'(busy), 64'd1);
    if (coin) chk("mt_with_start", 64'(hi), 64'(cval));
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (intrude && n == 10) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
        op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      if (intrude && n == 11) chk("busy_held", 64'(busy), 64'd1);
    end
    chk("latency", 64'(n), 64'd34);
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("model_hi", 64'(hi), 64'(eh));
    chk("model_lo", 64'(lo), 64'(el));
  endtask

  initial begin
    logic [31:0] ra, rb, w;
    logic [1:0]  ro;
    tests = 0; failed = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    // Start coincides with the first cycle after release.
    rst_n = 1'b1;
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);
    chk("multu_hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu_lo", 64'(lo), 64'h00000001);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("hi_stable", 64'(hi), 64'hFFFFFFFE);

    run_op(2'd0, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 32'd0);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFEB);
    // Back-to-back: next start issued in the DONE cycle.
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'd0);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);
    run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    run_op(2'd3, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("divu0_lo", 64'(lo), 64'hFFFFFFFF);
    chk("divu0_hi", 64'(hi), 64'd5);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);
    chk("divovf_lo", 64'(lo), 64'h80000000);
    chk("divovf_hi", 64'(hi), 64'd0);
    run_op(2'd2, 32'hFFFFFF00, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("div0_lo", 64'(lo), 64'hFFFFFFFF);
    chk("div0_hi", 64'(hi), 64'hFFFFFF00);
    @(negedge clk);

    // MTHI / MTLO in IDLE.
    hi_we = 1'b1; wdata = 32'hA5A5_1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi", 64'(hi), 64'hA5A51234);
    chk("mtlo", 64'(lo), 64'h0BADF00D);

    // Write coinciding with start lands, then the result overwrites it.
    hi_we = 1'b1; wdata = 32'h1357_9BDF;
    run_op(2'd1, 32'd6, 32'd9, 1'b0, 1'b1, 32'h13579BDF);
    chk("coin_lo", 64'(lo), 64'd54);
    chk("coin_hi", 64'(hi), 64'd0);
    @(negedge clk);

    // start and MTHI/MTLO on cycle 10 of a running MULT are ignored.
    run_op(2'd0, 32'h12345678, 32'hFEDCBA98, 1'b1, 1'b0, 32'd0);
    @(negedge clk);

    // Reset in cycle 20 of a DIV aborts; a MULTU right after release still works.
    start = 1'b1; op = 2'd2; src_a = 32'd1000; src_b = 32'hFFFFFFFD;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 20; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    chk("abort_no_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    run_op(2'd1, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0);
    chk("post_rst_lo", 64'(lo), 64'd12);
    @(negedge clk);

    // Randomized operations, a quarter of them issued back-to-back.
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom);
      case ($urandom_range(0, 4))
        0: ra = 32'h80000000;
        1: ra = $urandom_range(0, 50);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 1'b0, 1'b0, 32'd0);
      if ((i % 4) != 0) begin
        w = lo;
        @(negedge clk);
        chk("rand_done_pulse", 64'(done), 64'd0);
        chk("rand_lo_hold", 64'(lo), 64'(w));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
